// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing and counter-op decode for the register scoreboard.
// The optional REG_SCOREBOARD_WB_BYPASS_EN build is selected in reg_scoreboard.sv.
package reg_scoreboard_pkg;

    localparam int LEN_REGNO = 4;
    localparam int NUM_REG   = 2 ** LEN_REGNO;
    localparam int LEN_PEND  = 2;
    localparam logic [LEN_PEND-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        PEND_HOLD      = 2'd0,
        PEND_INC       = 2'd1,
        PEND_DEC       = 2'd2,
        PEND_UNDERFLOW = 2'd3
    } pend_op_e;

    // A simultaneous issue and writeback on one register cancel out, even at zero.
    function automatic pend_op_e pend_op(input logic inc, input logic dec, input logic zero);
        if (inc && !dec) begin
            return PEND_INC;
        end else if (dec && !inc) begin
            return zero ? PEND_UNDERFLOW : PEND_DEC;
        end
        return PEND_HOLD;
    endfunction

endpackage

// File: rtl/reg_scoreboard_pend_counter.sv
// One per-register in-flight write counter. Overflow is prevented upstream by
// the saturation hazard; a release at zero holds the count and flags underflow.
module reg_scoreboard_pend_counter
    import reg_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec,
    output logic [LEN_PEND-1:0] count,
    output logic                busy,
    output logic                full,
    output logic                underflow
);

    pend_op_e op;

    always_comb begin
        op = pend_op(inc, dec, count == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            case (op)
                PEND_INC: count <= count + LEN_PEND'(1);
                PEND_DEC: count <= count - LEN_PEND'(1);
                default:  count <= count;
            endcase
        end
    end

    assign busy      = (count != '0);
    assign full      = (count == PEND_MAX);
    assign underflow = (op == PEND_UNDERFLOW);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side RAW/saturation interlock with one pending-write counter per register.
// Define REG_SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback release the hazard.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [LEN_REGNO-1:0] rd_regno_i,
    input  logic [LEN_REGNO-1:0] rs_regno_i,
    input  logic                 rd_used_i,
    input  logic                 rs_used_i,
    input  logic                 writes_i,
    input  logic                 stall_i,
    output logic                 stall_o,
    output logic                 issue_o,
    input  logic                 wb_valid_i,
    input  logic [LEN_REGNO-1:0] wb_regno_i,
    output logic [NUM_REG-1:0]   busy_o,
    output logic                 reserved_o,
    output logic                 err_o
);

    // Handshake: the decoder holds an instruction while valid_i & stall_o; the
    // instruction transfers (issue_o) in any cycle with valid_i & ~stall_o.
    logic [LEN_PEND-1:0] pending [NUM_REG];
    logic [NUM_REG-1:0]  busy;
    logic [NUM_REG-1:0]  full;
    logic [NUM_REG-1:0]  underflow;
    logic [NUM_REG-1:0]  inc;
    logic [NUM_REG-1:0]  rel;
    logic [NUM_REG-1:0]  eff_busy;
    logic [NUM_REG-1:0]  eff_full;
    logic                hazard;
    logic                err;

    always_comb begin
        rel = '0;
        for (int n = 0; n < NUM_REG; n++) begin
            rel[n] = wb_valid_i && (wb_regno_i == LEN_REGNO'(n));
        end
    end

`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    // A register whose last outstanding write retires this cycle is already free.
    always_comb begin
        eff_busy = '0;
        eff_full = '0;
        for (int n = 0; n < NUM_REG; n++) begin
            eff_busy[n] = (pending[n] > LEN_PEND'(1)) ||
                          ((pending[n] == LEN_PEND'(1)) && !rel[n]);
            eff_full[n] = full[n] && !rel[n];
        end
    end
`else
    always_comb begin
        eff_busy = busy;
        eff_full = full;
    end
`endif

    always_comb begin
        hazard  = (rd_used_i && eff_busy[rd_regno_i]) ||
                  (rs_used_i && eff_busy[rs_regno_i]) ||
                  (writes_i  && eff_full[rd_regno_i]);
        stall_o = stall_i || (valid_i && hazard);
        issue_o = valid_i && !hazard && !stall_i;
    end

    always_comb begin
        inc = '0;
        for (int n = 0; n < NUM_REG; n++) begin
            inc[n] = issue_o && writes_i && (rd_regno_i == LEN_REGNO'(n));
        end
    end

    for (genvar g = 0; g < NUM_REG; g++) begin : g_pend
        reg_scoreboard_pend_counter u_pend (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc[g]),
            .dec       (rel[g]),
            .count     (pending[g]),
            .busy      (busy[g]),
            .full      (full[g]),
            .underflow (underflow[g])
        );
    end

    // Sticky until reset: a stray writeback means the pipe and scoreboard disagree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (|underflow) begin
            err <= 1'b1;
        end
    end

    assign busy_o     = busy;
    assign reserved_o = |busy;
    assign err_o      = err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed checks of reg_scoreboard: reset, RAW, saturation, simultaneous
// issue/writeback, underflow, downstream stall and mid-operation reset.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 valid_i = 1'b0;
    logic [LEN_REGNO-1:0] rd_regno_i = '0;
    logic [LEN_REGNO-1:0] rs_regno_i = '0;
    logic                 rd_used_i = 1'b0;
    logic                 rs_used_i = 1'b0;
    logic                 writes_i = 1'b0;
    logic                 stall_i = 1'b0;
    logic                 stall_o;
    logic                 issue_o;
    logic                 wb_valid_i = 1'b0;
    logic [LEN_REGNO-1:0] wb_regno_i = '0;
    logic [NUM_REG-1:0]   busy_o;
    logic                 reserved_o;
    logic                 err_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [NUM_REG-1:0] exp_q[$];

    reg_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .rd_regno_i (rd_regno_i),
        .rs_regno_i (rs_regno_i),
        .rd_used_i  (rd_used_i),
        .rs_used_i  (rs_used_i),
        .writes_i   (writes_i),
        .stall_i    (stall_i),
        .stall_o    (stall_o),
        .issue_o    (issue_o),
        .wb_valid_i (wb_valid_i),
        .wb_regno_i (wb_regno_i),
        .busy_o     (busy_o),
        .reserved_o (reserved_o),
        .err_o      (err_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_insn(input logic v, input logic [LEN_REGNO-1:0] rd,
                              input logic [LEN_REGNO-1:0] rs, input logic rdu,
                              input logic rsu, input logic wr);
        valid_i    = v;
        rd_regno_i = rd;
        rs_regno_i = rs;
        rd_used_i  = rdu;
        rs_used_i  = rsu;
        writes_i   = wr;
    endtask

    task automatic drive_wb(input logic v, input logic [LEN_REGNO-1:0] r);
        wb_valid_i = v;
        wb_regno_i = r;
    endtask

    task automatic check_hs(input string tag, input logic exp_stall, input logic exp_issue);
        #1;
        check({tag, "_stall"}, stall_o, exp_stall);
        check({tag, "_issue"}, issue_o, exp_issue);
    endtask

    // scoreboard: expected busy vectors in order
    task automatic sb_push(input logic [NUM_REG-1:0] b);
        exp_q.push_back(b);
    endtask

    task automatic sb_check(input string tag);
        logic [NUM_REG-1:0] e;
        #1;
        e = exp_q.pop_front();
        check({tag, "_busy"}, busy_o, e);
        check({tag, "_reserved"}, reserved_o, |e);
    endtask

    initial begin
        // reset with a stray writeback and a downstream stall applied
        drive_wb(1'b1, 4'd3);
        stall_i = 1'b1;
        repeat (3) next_cycle();
        sb_push('0);
        sb_check("reset");
        check("reset_err", err_o, 1'b0);
        check_hs("reset_follow", 1'b1, 1'b0);
        stall_i = 1'b0;
        check_hs("reset_clear", 1'b0, 1'b0);
        next_cycle();
        rst = 1'b1;
        drive_wb(1'b0, '0);
        check_hs("release", 1'b0, 1'b0);

        // RAW on r2
        next_cycle();
        drive_insn(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1);
        check_hs("raw_w2", 1'b0, 1'b1);
        next_cycle();
        drive_insn(1'b1, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0);
        check_hs("raw_dep", 1'b1, 1'b0);
        sb_push(16'h0004);
        sb_check("raw_pending");
        drive_wb(1'b1, 4'd2);
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
        check_hs("raw_wb_cycle", 1'b0, 1'b1);
`else
        check_hs("raw_wb_cycle", 1'b1, 1'b0);
`endif
        next_cycle();
        drive_wb(1'b0, '0);
        check_hs("raw_after_wb", 1'b0, 1'b1);
        sb_push('0);
        sb_check("raw_released");
        drive_insn(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check_hs("idle", 1'b0, 1'b0);

        // saturation on r5
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive_insn(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1);
            check_hs($sformatf("sat_fill%0d", i), 1'b0, 1'b1);
        end
        next_cycle();
        check_hs("sat_full", 1'b1, 1'b0);
        sb_push(16'h0020);
        sb_check("sat_full");
        drive_wb(1'b1, 4'd5);
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
        check_hs("sat_wb", 1'b0, 1'b1);
        next_cycle();
        drive_wb(1'b0, '0);
        check_hs("sat_refull", 1'b1, 1'b0);
`else
        check_hs("sat_wb", 1'b1, 1'b0);
        next_cycle();
        drive_wb(1'b0, '0);
        check_hs("sat_after_wb", 1'b0, 1'b1);
        next_cycle();
        check_hs("sat_refull", 1'b1, 1'b0);
`endif
        drive_insn(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive_wb(1'b1, 4'd5);
        repeat (3) next_cycle();
        drive_wb(1'b0, '0);
        sb_push('0);
        sb_check("sat_drained");
        check("sat_drained_err", err_o, 1'b0);

        // simultaneous issue and writeback on r7
        drive_insn(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 1'b1);
        check_hs("simul_w7", 1'b0, 1'b1);
        next_cycle();
        drive_wb(1'b1, 4'd7);
        check_hs("simul_p1", 1'b0, 1'b1);
        next_cycle();
        drive_insn(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive_wb(1'b0, '0);
        sb_push(16'h0080);
        sb_check("simul_p1");
        check("simul_p1_err", err_o, 1'b0);
        drive_wb(1'b1, 4'd7);
        next_cycle();
        drive_insn(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 1'b1);
        check_hs("simul_p0", 1'b0, 1'b1);
        next_cycle();
        drive_insn(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive_wb(1'b0, '0);
        sb_push('0);
        sb_check("simul_p0");
        check("simul_p0_err", err_o, 1'b0);

        // downstream stall without hazard
        stall_i = 1'b1;
        drive_insn(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1);
        check_hs("down_stall", 1'b1, 1'b0);
        next_cycle();
        stall_i = 1'b0;
        drive_insn(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        sb_push('0);
        sb_check("down_stall");

        // rd == rs, both read
        drive_insn(1'b1, 4'd4, 4'd0, 1'b0, 1'b0, 1'b1);
        check_hs("same_w4", 1'b0, 1'b1);
        next_cycle();
        drive_insn(1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 1'b0);
        check_hs("same_dep", 1'b1, 1'b0);
        sb_push(16'h0010);
        sb_check("same_pending");
        drive_wb(1'b1, 4'd4);
        next_cycle();
        drive_wb(1'b0, '0);
        check_hs("same_release", 1'b0, 1'b1);
        drive_insn(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // underflow on r9 is sticky
        drive_wb(1'b1, 4'd9);
        #1;
        check("uflow_before", err_o, 1'b0);
        next_cycle();
        drive_wb(1'b0, '0);
        #1;
        check("uflow_set", err_o, 1'b1);
        repeat (3) next_cycle();
        check("uflow_sticky", err_o, 1'b1);

        // reset mid-operation
        drive_insn(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        drive_insn(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        sb_push(16'h0008);
        sb_check("midrst_before");
        rst = 1'b0;
        sb_push('0);
        sb_check("midrst_after");
        check("midrst_err", err_o, 1'b0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-side hazard controller between insn_decoder and execute.
- Tracks in-flight register writes with one saturating pending counter per architectural register.
- Stalls the decoder on RAW hazards (rd/rs reads of a pending register) and on pending-counter saturation.
- Releases reservations on writeback; replaces the single-bit "reserved" interlock with per-register tracking.

Parameters:
- LEN_REGNO, 4, register-number width; NUM_REG = 2**LEN_REGNO registers.
- LEN_PEND, 2, pending-counter width; max in-flight writes per register = 2**LEN_PEND-1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset; asynchronous assert, active-low, synchronous release by the integrator.
- valid_i  input  1  decoder presents an instruction.
- rd_regno_i  input  LEN_REGNO  destination/first-source register.
- rs_regno_i  input  LEN_REGNO  second-source register.
- rd_used_i  input  1  instruction reads rd.
- rs_used_i  input  1  instruction reads rs (0 for immediate forms).
- writes_i  input  1  instruction writes rd.
- stall_i  input  1  downstream (execute) cannot accept.
- stall_o  output  1  to decoder: hold current instruction.
- issue_o  output  1  instruction accepted this cycle.
- wb_valid_i  input  1  writeback retiring a write this cycle.
- wb_regno_i  input  LEN_REGNO  register being written back.
- busy_o  output  NUM_REG  bit n = pending[n] != 0.
- reserved_o  output  1  OR of busy_o.
- err_o  output  1  sticky: writeback to a register with pending == 0.

Behaviour:
- State: pending[NUM_REG] of LEN_PEND bits, err flag. Reset (rst==0): all pending = 0, err_o = 0; therefore busy_o = 0, reserved_o = 0.
- stall_o and issue_o are combinational. While rst is low, the counters are 0, so no hazard exists; stall_o then follows stall_i.
- hazard = (rd_used_i & busy[rd]) | (rs_used_i & busy[rs]) | (writes_i & pending[rd] == MAX).
- busy[] is taken from registered counts. No same-cycle writeback bypass (see optional feature).
- stall_o = stall_i | (valid_i & hazard).
- issue_o = valid_i & ~hazard & ~stall_i.
- When valid_i = 0: stall_o = stall_i and issue_o = 0.
- Counter update per register n, each cycle:
  - inc = issue_o & writes_i & (rd_regno_i == n)
  - dec = wb_valid_i & (wb_regno_i == n)
  - inc & ~dec: pending+1 (never overflows; the saturation hazard prevents it).
  - dec & ~inc: pending-1 if pending != 0. If pending == 0, pending stays 0 and err flag sets.
  - inc & dec: unchanged. Applies even when pending == 0: net zero, no error.
- Latency: the count is visible on busy_o one cycle after issue/writeback.
- A dependent instruction stalls at least until the cycle after the matching writeback.
- rd == rs with both used: a single busy check; no special case.
- err flag clears only on reset.
- Reset mid-operation clears all reservations. Later writebacks from flushed instructions would raise err_o; the integrator flushes the pipe on the same reset.

Optional Feature:
- Macro: REG_SCOREBOARD_WB_BYPASS_EN.
- Defined: effective busy[n] for hazard evaluation = (pending[n] > 1) | (pending[n] == 1 & ~(wb_valid_i & wb_regno_i == n)). A dependent issues in the same cycle as the releasing writeback. The saturation check likewise subtracts a same-cycle release. busy_o still shows registered counts.
- Undefined: hazard uses registered counts only, giving one extra stall cycle after writeback.

Decomposition:
- Shared package/include (alongside defs_insn.v): LEN_REGNO, NUM_REG, LEN_PEND, PEND_MAX.
- One natural sub-module: pend_counter. It is one saturating up/down counter with inc, dec, count, busy and underflow outputs, instantiated NUM_REG times by generate.
- Hazard/issue logic stays in reg_scoreboard.

Test Plan:
- Reset: hold rst=0 with wb_valid_i=1, wb_regno_i=3 -> busy_o=0, reserved_o=0, err_o=0. Release rst; hold stall_i=0 -> stall_o=0.
- RAW, no bypass: issue writes r2. Next cycle valid_i, rs=2, rs_used=1 -> stall_o=1, issue_o=0. Assert wb_valid_i, wb_regno_i=2 -> stall_o=0 in the following cycle; busy_o[2] returns to 0.
- Saturation: issue 3 writes to r5 with reads disabled -> pending[5]=3. A 4th write -> stall_o=1. One wb of r5 -> the 4th issues the next cycle, pending stays 3.
- Simultaneous: issue write r7 while wb_valid_i r7 with pending[7]=1 -> pending[7] stays 1, err_o=0. The same at pending=0 -> stays 0, err_o=0.
- Underflow: wb_valid_i r9 with pending[9]=0 -> err_o=1 next cycle and stays 1 until rst=0.
- Downstream stall: stall_i=1, no hazard -> stall_o=1, issue_o=0, counters unchanged. With REG_SCOREBOARD_WB_BYPASS_EN, the RAW case issues in the writeback cycle.
